param_lifo: RTL and testbench
=============================

Name: param_lifo

Overview:
Parametrised synchronous LIFO (stack), the next generation of the team's 4-bit/16-entry stack. It adds configurable width and depth, uses all DEPTH entries, and supports a same-cycle push+pop (replace-top). It also provides an occupancy count, a registered read-valid strobe, and overflow/underflow error pulses. It sits between a producer/consumer pair that needs last-in-first-out ordering, for example context save/restore or expression-evaluation buffers.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, need not be a power of two)
AF_LEVEL, DEPTH-2, almost_full threshold; used only with LIFO_ALMOST_EN
AE_LEVEL, 2, almost_empty threshold; used only with LIFO_ALMOST_EN

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous reset, active-high
wr_en  in  1  push request
din  in  WIDTH  push data
rd_en  in  1  pop request
dout  out  WIDTH  popped data, registered
dout_valid  out  1  one-cycle strobe: dout updated this cycle
count  out  CW=$clog2(DEPTH+1)  current occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  one-cycle pulse: push rejected
underflow  out  1  one-cycle pulse: pop rejected
almost_full  out  1  only with LIFO_ALMOST_EN
almost_empty  out  1  only with LIFO_ALMOST_EN

Behaviour:
- Reset (asserted asynchronously, any time, including mid-operation) clears state immediately: count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Therefore empty=1 and full=0. Storage contents are not reset and are don't-care.
- Top of stack is mem[count-1]. full and empty are combinational decodes of count, with no extra state.
- Each cycle is decoded from {wr_en, rd_en}:
  - 00: idle. count holds. dout holds. dout_valid=0.
  - 10, not full: mem[count]<=din; count+1.
  - 10, full: overflow=1 for one cycle; no change to state.
  - 01, not empty: dout<=mem[count-1]; dout_valid=1; count-1.
  - 01, empty: underflow=1; dout holds; dout_valid=0.
  - 11, not empty (including full): replace-top. dout<=old mem[count-1]; dout_valid=1; mem[count-1]<=din; count unchanged. No overflow.
  - 11, empty: push executes (mem[0]<=din, count=1); pop rejected, so underflow=1 and dout_valid=0.
- Latency: popped data and dout_valid appear on the clock edge that accepts the pop (one registered stage). A pushed word is poppable on the next cycle.
- overflow, underflow and dout_valid are single-cycle pulses: they are cleared in any cycle without the triggering event.
- Arithmetic: count is CW bits and never wraps. Non-power-of-two DEPTH must not alias; index with count-1 only when count!=0.

Optional Feature:
- Macro: LIFO_ALMOST_EN.
- When defined: the almost_full and almost_empty ports exist and are registered. They are updated on the same edge as count, using next-count.
  - almost_full=1 when next count>=AF_LEVEL.
  - almost_empty=1 when next count<=AE_LEVEL.
  - Reset values: almost_full=0, almost_empty=1.
- When undefined: neither port exists, and AF_LEVEL/AE_LEVEL are ignored.

Decomposition:
- Package lifo_pkg:
  - enum lifo_op_e {OP_IDLE, OP_PUSH, OP_POP, OP_REPLACE}, the decoded per-cycle operation.
  - Default WIDTH/DEPTH localparams.
  - Function cnt_w(depth) returning $clog2(depth+1).
- One sub-module, lifo_mem: WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port. It has no reset.
- param_lifo owns the control, count and flags.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 and pop three times (WIDTH=8) -> dout 0x33,0x22,0x11 with dout_valid on each pop edge; then empty=1, count=0.
2. Fill all 16 entries, then push 0xAA -> full=1 and count=16; overflow pulses exactly one cycle; next pop returns entry 16, not 0xAA.
3. Pop when empty -> underflow one cycle, dout unchanged, dout_valid=0. Also wr_en=rd_en=1 when empty with din=0x5A -> count=1, underflow=1; a later pop gives 0x5A.
4. Stack holds 0x01,0x02, then wr_en=rd_en=1 with din=0x77 -> dout=0x02, count stays 2; next two pops give 0x77 then 0x01.
5. Assert rst asynchronously (mid-cycle) while count=5 and a push is in flight -> count=0 and empty=1 immediately, all pulses 0; first post-reset pop flags underflow.
6. With LIFO_ALMOST_EN defined, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2, push 15 then pop 14 -> almost_full rises on the 14th push and falls on the 2nd pop; almost_empty falls on the 3rd push and rises again when count returns to 2.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared types and sizing helpers for the parametrised LIFO.
package lifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } lifo_op_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module lifo_mem
    import lifo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_lifo.sv
// Parametrised LIFO with replace-top, occupancy count, read-valid strobe and error pulses.
// Define LIFO_ALMOST_EN to add the registered almost_full/almost_empty flags.
module param_lifo
    import lifo_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
`ifdef LIFO_ALMOST_EN
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
`endif
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef LIFO_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    localparam int AW = $clog2(DEPTH);

    lifo_op_e         op;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             is_full, is_empty;
    logic [AW-1:0]    top_idx, mem_waddr, mem_raddr;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rdata;

    assign is_full   = (count_q == CW'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign top_idx   = AW'(count_q - CW'(1));
    // Never present count-1 as an address while empty: it would alias for non-power-of-two DEPTH.
    assign mem_raddr = is_empty ? '0 : top_idx;

    always_comb begin
        op = OP_IDLE;
        if (wr_en && rd_en && !is_empty) begin
            op = OP_REPLACE;
        end else if (wr_en && !is_full) begin
            op = OP_PUSH;
        end else if (rd_en && !is_empty) begin
            op = OP_POP;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = AW'(count_q);
        overflow_d   = wr_en && !rd_en && is_full;
        underflow_d  = rd_en && is_empty;
        case (op)
            OP_PUSH: begin
                mem_we  = 1'b1;
                count_d = count_q + CW'(1);
            end
            OP_POP: begin
                dout_d       = mem_rdata;
                dout_valid_d = 1'b1;
                count_d      = count_q - CW'(1);
            end
            OP_REPLACE: begin
                dout_d       = mem_rdata;
                dout_valid_d = 1'b1;
                mem_we       = 1'b1;
                mem_waddr    = top_idx;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (din),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign full       = is_full;
    assign empty      = is_empty;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

`ifdef LIFO_ALMOST_EN
    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    assign almost_full_d  = (int'(count_d) >= AF_LEVEL);
    assign almost_empty_d = (int'(count_d) <= AE_LEVEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_param_lifo.sv
// Self-checking bench for param_lifo: directed scenarios plus randomized traffic against a queue model.
module tb_param_lifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
`ifdef LIFO_ALMOST_EN
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
`ifdef LIFO_ALMOST_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the stack itself plus the expected registered outputs.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_udf;

    always #5 clk = ~clk;

    param_lifo #(
        .WIDTH    (WIDTH),
`ifdef LIFO_ALMOST_EN
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
`endif
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
`ifdef LIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .underflow    (underflow)
    );

    task automatic model_step(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        if (wr && rd) begin
            if (model_q.size() == 0) begin
                model_q.push_back(d);
                exp_udf = 1'b1;
            end else begin
                exp_dout  = model_q[model_q.size()-1];
                model_q[model_q.size()-1] = d;
                exp_valid = 1'b1;
            end
        end else if (wr) begin
            if (model_q.size() == DEPTH) exp_ovf = 1'b1;
            else model_q.push_back(d);
        end else if (rd) begin
            if (model_q.size() == 0) begin
                exp_udf = 1'b1;
            end else begin
                exp_dout  = model_q.pop_back();
                exp_valid = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the active edge.
    task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        model_step(wr, rd, d);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #1 rst = 1'b1;
        #2;
        tests_run++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
        end
        tests_run++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: dout=%h valid=%b ovf=%b udf=%b, want 00/0/0/0",
                     dout, dout_valid, overflow, underflow);
        end
`ifdef LIFO_ALMOST_EN
        tests_run++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_almost: af=%b ae=%b, want 0/1", almost_full, almost_empty);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_lifo_order();
        logic [WIDTH-1:0] pushes [3] = '{8'h11, 8'h22, 8'h33};
        logic [WIDTH-1:0] pops   [3] = '{8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, pushes[i]);
        tests_run++;
        if (count !== 5'd3 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_count: count=%0d valid=%b, want 3/0", count, dout_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, '0);
            tests_run++;
            if (dout !== pops[i] || dout_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL order_pop%0d: dout=%h valid=%b, want %h/1", i, dout, dout_valid, pops[i]);
            end
        end
        tests_run++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL order_empty: count=%0d empty=%b, want 0/1", count, empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, WIDTH'(i));
        tests_run++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, want 1/16/0", full, count, overflow);
        end
        drive(1'b1, 1'b0, 8'hAA);
        tests_run++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_pulse: ovf=%b count=%0d full=%b, want 1/16/1", overflow, count, full);
        end
        drive(1'b0, 1'b0, '0);
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: ovf=%b, want 0", overflow);
        end
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (dout !== 8'h10 || dout_valid !== 1'b1 || count !== 5'd15) begin
            tests_failed++;
            $display("FAIL overflow_top: dout=%h valid=%b count=%0d, want 10/1/15", dout, dout_valid, count);
        end
        for (int i = 15; i >= 1; i--) begin
            drive(1'b0, 1'b1, '0);
            tests_run++;
            if (dout !== WIDTH'(i)) begin
                tests_failed++;
                $display("FAIL drain_%0d: dout=%h, want %h", i, dout, WIDTH'(i));
            end
        end
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'h01 || count !== 5'd0) begin
            tests_failed++;
            $display("FAIL underflow_pop: udf=%b valid=%b dout=%h count=%0d, want 1/0/01/0",
                     underflow, dout_valid, dout, count);
        end
        drive(1'b0, 1'b0, '0);
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_clear: udf=%b, want 0", underflow);
        end
        drive(1'b1, 1'b1, 8'h5A);
        tests_run++;
        if (count !== 5'd1 || underflow !== 1'b1 || dout_valid !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_empty: count=%0d udf=%b valid=%b ovf=%b, want 1/1/0/0",
                     count, underflow, dout_valid, overflow);
        end
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (dout !== 8'h5A || dout_valid !== 1'b1 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL both_empty_pop: dout=%h valid=%b udf=%b, want 5A/1/0", dout, dout_valid, underflow);
        end
    endtask

    task automatic test_replace();
        drive(1'b1, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b1, 8'h77);
        tests_run++;
        if (dout !== 8'h02 || dout_valid !== 1'b1 || count !== 5'd2 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL replace: dout=%h valid=%b count=%0d ovf=%b udf=%b, want 02/1/2/0/0",
                     dout, dout_valid, count, overflow, underflow);
        end
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (dout !== 8'h77) begin
            tests_failed++;
            $display("FAIL replace_pop1: dout=%h, want 77", dout);
        end
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (dout !== 8'h01 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL replace_pop2: dout=%h empty=%b, want 01/1", dout, empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, WIDTH'(8'hC0 + i));
        drive(1'b1, 1'b1, 8'hC9);
        tests_run++;
        if (count !== 5'd5 || dout !== 8'hC4) begin
            tests_failed++;
            $display("FAIL pre_reset: count=%0d dout=%h, want 5/C4", count, dout);
        end
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b0;
        din   = 8'hEE;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: count=%0d empty=%b full=%b dout=%h, want 0/1/0/00",
                     count, empty, full, dout);
        end
        tests_run++;
        if (dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_pulses: valid=%b ovf=%b udf=%b, want 0/0/0",
                     dout_valid, overflow, underflow);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (count !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: count=%0d, want 0", count);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        model_reset();
        drive(1'b0, 1'b1, '0);
        tests_run++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset_pop: udf=%b valid=%b dout=%h, want 1/0/00", underflow, dout_valid, dout);
        end
    endtask

`ifdef LIFO_ALMOST_EN
    task automatic test_almost();
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 1'b0, WIDTH'(i));
            tests_run++;
            if (almost_full !== (i >= AF_LEVEL) || almost_empty !== (i <= AE_LEVEL)) begin
                tests_failed++;
                $display("FAIL almost_push%0d: af=%b ae=%b, want %b/%b", i, almost_full, almost_empty,
                         (i >= AF_LEVEL), (i <= AE_LEVEL));
            end
        end
        for (int j = 1; j <= 14; j++) begin
            drive(1'b0, 1'b1, '0);
            tests_run++;
            if (almost_full !== ((15 - j) >= AF_LEVEL) || almost_empty !== ((15 - j) <= AE_LEVEL)) begin
                tests_failed++;
                $display("FAIL almost_pop%0d: af=%b ae=%b, want %b/%b", j, almost_full, almost_empty,
                         ((15 - j) >= AF_LEVEL), ((15 - j) <= AE_LEVEL));
            end
        end
        drive(1'b0, 1'b1, '0);
    endtask
`endif

    task automatic test_random();
        logic wr, rd, push_phase;
        for (int c = 0; c < 600; c++) begin
            push_phase = ((c / 60) % 2) == 0;
            wr = $urandom_range(0, 99) < (push_phase ? 80 : 30);
            rd = $urandom_range(0, 99) < (push_phase ? 25 : 75);
            drive(wr, rd, WIDTH'($urandom));
            tests_run++;
            if (dout !== exp_dout || dout_valid !== exp_valid || overflow !== exp_ovf || underflow !== exp_udf) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: dout=%h v=%b o=%b u=%b, want %h/%b/%b/%b", c,
                         dout, dout_valid, overflow, underflow, exp_dout, exp_valid, exp_ovf, exp_udf);
            end
            tests_run++;
            if (count !== CW'(model_q.size()) || full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
                tests_failed++;
                $display("FAIL rand_count[%0d]: count=%0d full=%b empty=%b, want %0d", c,
                         count, full, empty, model_q.size());
            end
`ifdef LIFO_ALMOST_EN
            tests_run++;
            if (almost_full !== (model_q.size() >= AF_LEVEL) || almost_empty !== (model_q.size() <= AE_LEVEL)) begin
                tests_failed++;
                $display("FAIL rand_almost[%0d]: af=%b ae=%b size=%0d", c, almost_full, almost_empty, model_q.size());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_lifo_order();
        test_overflow();
        test_underflow();
        test_replace();
        test_async_reset();
`ifdef LIFO_ALMOST_EN
        test_almost();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
